// File: rtl/len_counter_pkg.sv
// Shared defaults and count types for the sound-channel length counter.
// The optional `remaining` output is enabled with LEN_COUNTER_REMAIN_EN.
package len_counter_pkg;

    localparam int TMR_W_DEF   = 7;
    localparam int LEN_W_DEF   = 6;
    localparam int LEN_MAX_DEF = 2 ** LEN_W_DEF;

    typedef logic [TMR_W_DEF-1:0] tmr_cnt_t;
    typedef logic [LEN_W_DEF:0]   len_cnt_t;

endpackage

// File: rtl/len_counter_var_timer.sv
// Free-running programmable divider: one-cycle registered tick every `period` clocks.
// A period of zero halts the timer and holds its count at zero.
module var_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // >= rather than == so a period lowered below the current count wraps at once
    always_comb begin
        count_d = count_q + WIDTH'(1);
        tick_d  = 1'b0;
        if (period == '0) begin
            count_d = '0;
        end else if (count_q >= (period - WIDTH'(1))) begin
            count_d = '0;
            tick_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/len_counter.sv
// Channel length counter: a trigger loads LEN_MAX-len_load, each timer tick counts down,
// and chan_enable drops when the count reaches zero. Define LEN_COUNTER_REMAIN_EN for `remaining`.
module len_counter
    import len_counter_pkg::*;
#(
    parameter int TMR_W = TMR_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TMR_W-1:0] period,
    input  logic [LEN_W-1:0] len_load,
    input  logic             trigger,
    input  logic             len_enable,
    output logic             tick,
    output logic             chan_enable
`ifdef LEN_COUNTER_REMAIN_EN
    ,
    output logic [LEN_W:0]   remaining
`endif
);

    localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

    logic           tmr_tick;
    logic [LEN_W:0] len_q, len_d;
    logic           chan_q, chan_d;

    var_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .period (period),
        .tick   (tmr_tick)
    );

    // Trigger wins over a coincident tick; a zero count is sticky until the next trigger
    always_comb begin
        len_d  = len_q;
        chan_d = chan_q;
        if (trigger) begin
            len_d  = LEN_MAX - {1'b0, len_load};
            chan_d = 1'b1;
        end else if (tmr_tick && len_enable && (len_q != '0)) begin
            len_d = len_q - (LEN_W+1)'(1);
            if (len_q == (LEN_W+1)'(1)) begin
                chan_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q  <= '0;
            chan_q <= 1'b0;
        end else begin
            len_q  <= len_d;
            chan_q <= chan_d;
        end
    end

    assign tick        = tmr_tick;
    assign chan_enable = chan_q;
`ifdef LEN_COUNTER_REMAIN_EN
    assign remaining   = len_q;
`endif

endmodule

// File: tb/tb_len_counter.sv
// Randomized scoreboard bench for len_counter: a cycle-level reference model queues the
// expected outputs for every edge and an independent monitor compares them after each edge.
module tb_len_counter;

    localparam int TMR_W   = 7;
    localparam int LEN_W   = 6;
    localparam int LEN_MAX = 2 ** LEN_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [TMR_W-1:0] period = '0;
    logic [LEN_W-1:0] len_load = '0;
    logic             trigger = 1'b0;
    logic             len_enable = 1'b0;
    logic             tick;
    logic             chan_enable;
`ifdef LEN_COUNTER_REMAIN_EN
    logic [LEN_W:0]   remaining;
`endif

    len_counter #(.TMR_W(TMR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .period      (period),
        .len_load    (len_load),
        .trigger     (trigger),
        .len_enable  (len_enable),
        .tick        (tick),
        .chan_enable (chan_enable)
`ifdef LEN_COUNTER_REMAIN_EN
        ,
        .remaining   (remaining)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int tick;
        int chan;
        int len;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   txn_id   = 0;

    // Reference model state, held as plain integers
    int m_phase = 0;   // cycles elapsed in the current timer period
    int m_tick  = 0;
    int m_len   = 0;
    int m_chan  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_tick  = 0;
        m_len   = 0;
        m_chan  = 0;
    endtask

    // Outputs after the next edge, computed from the current model state and inputs
    task automatic model_edge();
        int p;
        int nt;
        p = int'(period);
        if (p == 0) begin
            m_phase = 0;
            nt = 0;
        end else if (m_phase + 1 >= p) begin
            m_phase = 0;
            nt = 1;
        end else begin
            m_phase = m_phase + 1;
            nt = 0;
        end
        if (trigger) begin
            m_len  = LEN_MAX - int'(len_load);
            m_chan = 1;
        end else if (m_tick == 1 && len_enable && m_len > 0) begin
            m_len = m_len - 1;
            if (m_len == 0) m_chan = 0;
        end
        m_tick = nt;
    endtask

    // Called at a negedge: apply inputs, queue expectation, advance to next negedge
    task automatic step(input int per, input int ld, input int trg, input int en);
        exp_t e;
        period     = TMR_W'(per);
        len_load   = LEN_W'(ld);
        trigger    = trg[0];
        len_enable = en[0];
        model_edge();
        e.tick = m_tick;
        e.chan = m_chan;
        e.len  = m_len;
        e.id   = txn_id++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tick", int'(tick), e.tick);
            check("chan_enable", int'(chan_enable), e.chan);
`ifdef LEN_COUNTER_REMAIN_EN
            check("remaining", int'(remaining), e.len);
`endif
            $display("txn %0d: tick=%0d chan_enable=%0d exp_len=%0d", e.id, tick, chan_enable, e.len);
        end
    end

    // Asynchronous reset asserted between edges, then released at a negedge
    task automatic mid_reset();
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_tick_async", int'(tick), 0);
        check("reset_chan_async", int'(chan_enable), 0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_tick_held", int'(tick), 0);
        check("reset_chan_held", int'(chan_enable), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int high_cnt;
        int seen_low;
        int per;

        @(negedge clk);
        check("reset_tick", int'(tick), 0);
        check("reset_chan", int'(chan_enable), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // period=3, no trigger: tick 0,0,1 repeating, channel idle
        for (int i = 0; i < 12; i++) step(3, 0, 0, 1);

        // period=2, len_load=62: two ticks drain the channel
        step(2, 62, 1, 1);
        for (int i = 0; i < 8; i++) step(2, 62, 0, 1);

        // period=1, len_load=0: exactly 64 cycles of chan_enable
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        high_cnt = 1;
        seen_low = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 0, 0, 1);
            #2;
            if (chan_enable && !seen_low) high_cnt++;
            else seen_low = 1;
        end
        check("full_length_cycles", high_cnt, LEN_MAX);

        // Length frozen: channel stays on, then drains once counting resumes
        step(5, 63, 1, 0);
        for (int i = 0; i < 200; i++) step(5, 63, 0, 0);
        for (int i = 0; i < 12; i++) step(5, 63, 0, 1);

        // Retrigger coincident with the tick that would consume count=1
        step(1, 63, 1, 1);
        step(1, 63, 1, 1);
        step(1, 63, 0, 1);
        step(1, 63, 0, 1);

        // Mid-count reset, then a halted timer
        step(2, 10, 1, 1);
        for (int i = 0; i < 5; i++) step(2, 10, 0, 1);
        mid_reset();
        for (int i = 0; i < 10; i++) step(0, 10, 0, 1);

        // Random traffic with occasional period changes
        per = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) per = $urandom_range(0, 9);
            step(per, $urandom_range(0, LEN_MAX - 1),
                 ($urandom_range(0, 99) < 4) ? 1 : 0,
                 ($urandom_range(0, 99) < 85) ? 1 : 0);
            if (i == 1500) mid_reset();
        end

        step(per, 0, 0, 1);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
